logic_unit_pipe: RTL



---
 rtl/logic_unit_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Purpose: eight-operation bitwise logic unit with accumulator chaining, zero/parity flags and beat counter.
// Latency: one cycle; a beat accepted at edge N is presented on y with out_valid=1 after edge N.
// Backpressure: one-entry output register; in_ready = !out_valid || out_ready, full throughput when out_ready stays high.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             parity;
    } res_t;

    state_t           state;
    state_t           state_nxt;
    res_t             res_q;
    res_t             res_d;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_opnd;
    logic             accept;

    assign in_ready  = (state == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);
    assign y         = res_q.y;
    assign zero      = res_q.zero;
    assign parity    = res_q.parity;

    // Second operand: b, the accumulator, or zero when the accumulator is cleared in the same beat.
    always_comb begin
        x_opnd = b;
        if (acc_en) begin
            x_opnd = clr_acc ? '0 : acc;
        end
    end

    // Bitwise operation select and flag generation for the candidate result.
    always_comb begin
        res_d   = '0;
        res_d.y = a;
        case (op)
            3'b000: res_d.y = a & x_opnd;
            3'b001: res_d.y = ~(a & x_opnd);
            3'b010: res_d.y = a | x_opnd;
            3'b011: res_d.y = ~(a | x_opnd);
            3'b100: res_d.y = a ^ x_opnd;
            3'b101: res_d.y = ~(a ^ x_opnd);
            3'b110: res_d.y = ~a;
            3'b111: res_d.y = a;
            default: res_d.y = a;
        endcase
        res_d.zero   = (res_d.y == '0);
        res_d.parity = ^res_d.y;
    end

    // Output register occupancy: EMPTY/FULL next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (out_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Result register loads only on accept, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (accept) begin
            res_q <= res_d;
        end
    end

    // Accumulator follows every accepted result; an idle clr_acc zeroes it, an accepted result wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= res_d.y;
        end else if (clr_acc) begin
            acc <= '0;
        end
    end

    // Accepted-beat counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
